// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: bus widths, funct3 size codes, FSM encoding, and
// request decode helpers used by the load/store unit and its extender.
package load_store_unit_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int WORD_LEN  = 32;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return funct3 inside {FUNCT3_B, FUNCT3_H, FUNCT3_W};
        end
        return funct3 inside {FUNCT3_B, FUNCT3_H, FUNCT3_W, FUNCT3_BU, FUNCT3_HU};
    endfunction

    // Index of the final byte access: 0 for aligned, 1 for split half, 3 for split word.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            FUNCT3_H, FUNCT3_HU: return addr_lo[0] ? 2'd1 : 2'd0;
            FUNCT3_W:            return (addr_lo != 2'b00) ? 2'd3 : 2'd0;
            default:             return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled load value according to its funct3 code.
module lsu_extend
    import load_store_unit_pkg::*;
(
    input  logic [WORD_LEN-1:0] data_i,
    input  logic [2:0]          funct3_i,
    output logic [WORD_LEN-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (funct3_i)
            FUNCT3_B:  data_o = {{24{data_i[7]}}, data_i[7:0]};
            FUNCT3_H:  data_o = {{16{data_i[15]}}, data_i[15:0]};
            FUNCT3_BU: data_o = {24'h0, data_i[7:0]};
            FUNCT3_HU: data_o = {16'h0, data_i[15:0]};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: aligned accesses pass straight through in one cycle, misaligned
// halves/words are split into ascending byte accesses and reassembled.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [2:0]           reqFunct3,
    input  logic [ADDR_SIZE-1:0] reqAddr,
    input  logic [WORD_LEN-1:0]  reqWriteData,
    output logic                 rspValid,
    output logic [WORD_LEN-1:0]  rspData,
    output logic                 rspError,
    output logic                 memWriteEnable,
    output logic [ADDR_SIZE-1:0] memAddr,
    output logic [2:0]           memUnitSize,
    output logic [WORD_LEN-1:0]  memWriteData,
    input  logic [WORD_LEN-1:0]  memReadData
);

    lsu_state_e           state_q;
    logic                 write_q;
    logic [2:0]           funct3_q;
    logic [WORD_LEN-1:0]  wdata_q;
    logic [1:0]           byte_cnt_q;
    logic [1:0]           last_q;
    logic                 split_q;
    logic [WORD_LEN-1:0]  buf_q;
    logic [WORD_LEN-1:0]  buf_d;
    logic [WORD_LEN-1:0]  ext_data;
    logic [ADDR_SIZE-1:0] mem_addr_q;
    logic [2:0]           mem_size_q;
    logic [WORD_LEN-1:0]  mem_wdata_q;
    logic                 mem_we_q;
    logic                 rsp_valid_q;
    logic                 rsp_error_q;
    logic [WORD_LEN-1:0]  rsp_data_q;

    logic                 req_legal;
    logic [1:0]           req_last;
    logic [1:0]           cnt_d;
    logic [7:0]           next_wbyte;

    assign req_legal  = funct3_legal(reqWrite, reqFunct3);
    assign req_last   = last_byte_idx(reqFunct3, reqAddr[1:0]);
    assign cnt_d      = byte_cnt_q + 2'd1;
    assign next_wbyte = wdata_q[{cnt_d, 3'b000} +: 8];

    // Assembly buffer with the byte being read this cycle merged in.
    always_comb begin
        buf_d = buf_q;
        buf_d[{byte_cnt_q, 3'b000} +: 8] = memReadData[7:0];
    end

    lsu_extend u_extend (
        .data_i   (buf_d),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= LSU_IDLE;
            write_q     <= 1'b0;
            funct3_q    <= FUNCT3_W;
            wdata_q     <= '0;
            byte_cnt_q  <= 2'd0;
            last_q      <= 2'd0;
            split_q     <= 1'b0;
            buf_q       <= '0;
            mem_addr_q  <= '0;
            mem_size_q  <= FUNCT3_W;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (reqValid) begin
                        write_q    <= reqWrite;
                        funct3_q   <= reqFunct3;
                        wdata_q    <= reqWriteData;
                        byte_cnt_q <= 2'd0;
                        buf_q      <= '0;
                        last_q     <= req_last;
                        split_q    <= (req_last != 2'd0);
                        if (!req_legal) begin
                            state_q     <= LSU_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q    <= LSU_ACCESS;
                            mem_addr_q <= reqAddr;
                            mem_we_q   <= reqWrite;
                            if (req_last != 2'd0) begin
                                mem_size_q  <= reqWrite ? FUNCT3_B : FUNCT3_BU;
                                mem_wdata_q <= reqWrite ? {24'h0, reqWriteData[7:0]} : '0;
                            end else begin
                                mem_size_q  <= reqFunct3;
                                mem_wdata_q <= reqWrite ? reqWriteData : '0;
                            end
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (byte_cnt_q == last_q) begin
                        state_q     <= LSU_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_data_q  <= write_q ? '0 : (split_q ? ext_data : memReadData);
                        buf_q       <= buf_d;
                        mem_addr_q  <= '0;
                        mem_size_q  <= FUNCT3_W;
                        mem_wdata_q <= '0;
                        mem_we_q    <= 1'b0;
                    end else begin
                        // Next byte of a split access; address wraps naturally at 2^32.
                        byte_cnt_q  <= cnt_d;
                        buf_q       <= buf_d;
                        mem_addr_q  <= mem_addr_q + 1'b1;
                        mem_wdata_q <= write_q ? {24'h0, next_wbyte} : '0;
                    end
                end
                default: begin
                    state_q     <= LSU_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_error_q <= 1'b0;
                    rsp_data_q  <= '0;
                    byte_cnt_q  <= 2'd0;
                    buf_q       <= '0;
                end
            endcase
        end
    end

    assign reqReady       = (state_q == LSU_IDLE);
    assign rspValid       = rsp_valid_q;
    assign rspData        = rsp_data_q;
    assign rspError       = rsp_error_q;
    assign memWriteEnable = mem_we_q;
    assign memAddr        = mem_addr_q;
    assign memUnitSize    = mem_size_q;
    assign memWriteData   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory model plus a response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        reqValid, reqReady, reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr, reqWriteData;
    logic        rspValid, rspError;
    logic [31:0] rspData;
    logic        memWriteEnable;
    logic [31:0] memAddr, memWriteData, memReadData;
    logic [2:0]  memUnitSize;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;
    rsp_t sb_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqWrite       (reqWrite),
        .reqFunct3      (reqFunct3),
        .reqAddr        (reqAddr),
        .reqWriteData   (reqWriteData),
        .rspValid       (rspValid),
        .rspData        (rspData),
        .rspError       (rspError),
        .memWriteEnable (memWriteEnable),
        .memAddr        (memAddr),
        .memUnitSize    (memUnitSize),
        .memWriteData   (memWriteData),
        .memReadData    (memReadData)
    );

    // Memory model indexed by the low 12 address bits (enough for the addresses used).
    logic [7:0]  mem [0:4095];
    logic        mem_clr_req;
    logic [11:0] ma0, ma1, ma2, ma3;
    logic [7:0]  b0, b1, b2, b3;
    assign ma0 = memAddr[11:0];
    assign ma1 = memAddr[11:0] + 12'd1;
    assign ma2 = memAddr[11:0] + 12'd2;
    assign ma3 = memAddr[11:0] + 12'd3;
    assign b0 = mem[ma0];
    assign b1 = mem[ma1];
    assign b2 = mem[ma2];
    assign b3 = mem[ma3];

    always_comb begin
        case (memUnitSize)
            3'b000:  memReadData = {{24{b0[7]}}, b0};
            3'b001:  memReadData = {{16{b1[7]}}, b1, b0};
            3'b010:  memReadData = {b3, b2, b1, b0};
            3'b100:  memReadData = {24'h0, b0};
            3'b101:  memReadData = {16'h0, b1, b0};
            default: memReadData = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_clr_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
        end else if (memWriteEnable) begin
            mem[ma0] <= memWriteData[7:0];
            if (memUnitSize == 3'b001 || memUnitSize == 3'b010) mem[ma1] <= memWriteData[15:8];
            if (memUnitSize == 3'b010) begin
                mem[ma2] <= memWriteData[23:16];
                mem[ma3] <= memWriteData[31:24];
            end
        end
    end

    function automatic int tb_accesses(input logic [2:0] f3, input logic [31:0] a);
        if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 2;
        if (f3 == 3'b010 && a[1:0] != 2'b00) return 4;
        return 1;
    endfunction

    // One request: push the expected response, drive it, check every ACCESS cycle and the RESP cycle.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_err, input logic noisy);
        int          nacc;
        logic [31:0] eaddr, ewd;
        logic [2:0]  esize;
        rsp_t        exp;
        nacc = exp_err ? 0 : tb_accesses(f3, addr);
        sb_q.push_back('{exp_data, exp_err});
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqFunct3 = f3; reqAddr = addr; reqWriteData = wdata;
        tests_run++;
        if (reqReady !== 1'b1) begin
            tests_failed++; $display("FAIL req_ready @%h: got %b want 1", addr, reqReady);
        end
        @(posedge clk); #1;
        if (noisy) begin
            reqWrite = 1'b1; reqFunct3 = 3'b010; reqAddr = 32'h500; reqWriteData = 32'hFFFF_FFFF;
        end else begin
            reqValid = 1'b0;
        end
        for (int i = 0; i < nacc; i++) begin
            @(negedge clk);
            eaddr = addr + 32'(i);
            esize = (nacc > 1) ? (w ? 3'b000 : 3'b100) : f3;
            ewd   = (nacc > 1) ? {24'h0, wdata[8*i +: 8]} : wdata;
            tests_run += 5;
            if (memAddr !== eaddr) begin
                tests_failed++; $display("FAIL mem_addr[%0d]: got %h want %h", i, memAddr, eaddr);
            end
            if (memUnitSize !== esize) begin
                tests_failed++; $display("FAIL unit_size[%0d] @%h: got %b want %b", i, addr, memUnitSize, esize);
            end
            if (memWriteEnable !== w) begin
                tests_failed++; $display("FAIL write_en[%0d] @%h: got %b want %b", i, addr, memWriteEnable, w);
            end
            if (reqReady !== 1'b0 || rspValid !== 1'b0) begin
                tests_failed++; $display("FAIL busy[%0d] @%h: ready %b valid %b want 0 0", i, addr, reqReady, rspValid);
            end
            if (w && memWriteData !== ewd) begin
                tests_failed++; $display("FAIL wdata[%0d] @%h: got %h want %h", i, addr, memWriteData, ewd);
            end
        end
        @(negedge clk);
        exp = sb_q.pop_front();
        tests_run += 4;
        if (rspValid !== 1'b1) begin
            tests_failed++; $display("FAIL rsp_valid @%h: got %b want 1", addr, rspValid);
        end
        if (rspData !== exp.data) begin
            tests_failed++; $display("FAIL rsp_data @%h: got %h want %h", addr, rspData, exp.data);
        end
        if (rspError !== exp.err) begin
            tests_failed++; $display("FAIL rsp_error @%h: got %b want %b", addr, rspError, exp.err);
        end
        if (memWriteEnable !== 1'b0) begin
            tests_failed++; $display("FAIL we_in_resp @%h: got %b want 0", addr, memWriteEnable);
        end
        reqValid = 1'b0;
        $display("[TB] req w=%b f3=%b addr=%h -> data=%h err=%b", w, f3, addr, rspData, rspError);
    endtask

    task automatic check_mem(input logic [11:0] idx, input logic [7:0] want);
        tests_run++;
        if (mem[idx] !== want) begin
            tests_failed++; $display("FAIL mem[%h]: got %h want %h", idx, mem[idx], want);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests_run += 4;
        if (reqReady !== 1'b1 || rspValid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_handshake: ready %b valid %b want 1 0", reqReady, rspValid);
        end
        if (rspData !== 32'h0 || rspError !== 1'b0) begin
            tests_failed++; $display("FAIL reset_rsp: data %h err %b want 0 0", rspData, rspError);
        end
        if (memWriteEnable !== 1'b0 || memAddr !== 32'h0 || memWriteData !== 32'h0) begin
            tests_failed++; $display("FAIL reset_mem: we %b addr %h wd %h want 0", memWriteEnable, memAddr, memWriteData);
        end
        if (memUnitSize !== 3'b010) begin
            tests_failed++; $display("FAIL reset_size: got %b want 010", memUnitSize);
        end
    endtask

    task automatic test_aligned_store;
        do_req(1'b1, 3'b010, 32'h100, 32'h8899AABB, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 3'b010, 32'h200, 32'h44332211, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 3'b010, 32'h204, 32'h88776655, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 3'b001, 32'hFFFFFFFE, 32'h00002211, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 3'b001, 32'h0, 32'h00004433, 32'h0, 1'b0, 1'b0);
        check_mem(12'h103, 8'h88);
        check_mem(12'hFFF, 8'h22);
    endtask

    task automatic test_aligned_load;
        do_req(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 1'b0, 1'b0);
        do_req(1'b0, 3'b100, 32'h100, 32'h0, 32'h000000BB, 1'b0, 1'b0);
        do_req(1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0);
        do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 1'b0, 1'b0);
        do_req(1'b0, 3'b101, 32'h102, 32'h0, 32'h00008899, 1'b0, 1'b0);
    endtask

    task automatic test_misaligned_load;
        do_req(1'b0, 3'b010, 32'h203, 32'h0, 32'h77665544, 1'b0, 1'b0);
        do_req(1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFF99AA, 1'b0, 1'b0);
        do_req(1'b0, 3'b101, 32'h101, 32'h0, 32'h000099AA, 1'b0, 1'b0);
        do_req(1'b0, 3'b001, 32'h205, 32'h0, 32'h00007766, 1'b0, 1'b0);
        do_req(1'b0, 3'b010, 32'h201, 32'h0, 32'h55443322, 1'b0, 1'b0);
    endtask

    task automatic test_misaligned_store;
        do_req(1'b1, 3'b001, 32'h301, 32'h0000BEEF, 32'h0, 1'b0, 1'b0);
        check_mem(12'h300, 8'h00);
        check_mem(12'h301, 8'hEF);
        check_mem(12'h302, 8'hBE);
        check_mem(12'h303, 8'h00);
        do_req(1'b0, 3'b101, 32'h301, 32'h0, 32'h0000BEEF, 1'b0, 1'b0);
        do_req(1'b1, 3'b010, 32'h305, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 3'b010, 32'h305, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        check_mem(12'h308, 8'hCA);
        check_mem(12'h500, 8'h00);
    endtask

    task automatic test_wrap;
        do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 32'h44332211, 1'b0, 1'b0);
        do_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 32'h00003322, 1'b0, 1'b0);
    endtask

    task automatic test_illegal;
        do_req(1'b1, 3'b100, 32'h300, 32'h000000FF, 32'h0, 1'b1, 1'b0);
        check_mem(12'h300, 8'h00);
        do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req(1'b1, 3'b111, 32'h100, 32'h12345678, 32'h0, 1'b1, 1'b0);
        check_mem(12'h100, 8'hBB);
    endtask

    task automatic test_back_to_back;
        do_req(1'b1, 3'b000, 32'h310, 32'h0000005A, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 3'b100, 32'h310, 32'h0, 32'h0000005A, 1'b0, 1'b0);
        do_req(1'b1, 3'b000, 32'h311, 32'h00000080, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 3'b000, 32'h311, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
        do_req(1'b0, 3'b101, 32'h310, 32'h0, 32'h0000805A, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b010; reqAddr = 32'h401; reqWriteData = 32'hA1B2C3D4;
        @(posedge clk); #1;
        reqValid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (memAddr !== 32'h403) begin
            tests_failed++; $display("FAIL midop_byte2_addr: got %h want 00000403", memAddr);
        end
        rstn = 1'b0;
        #1;
        tests_run += 3;
        if (rspValid !== 1'b0 || rspData !== 32'h0 || rspError !== 1'b0) begin
            tests_failed++; $display("FAIL midop_rsp: valid %b data %h err %b want 0", rspValid, rspData, rspError);
        end
        if (memWriteEnable !== 1'b0 || memAddr !== 32'h0 || memWriteData !== 32'h0) begin
            tests_failed++; $display("FAIL midop_mem: we %b addr %h wd %h want 0", memWriteEnable, memAddr, memWriteData);
        end
        if (memUnitSize !== 3'b010) begin
            tests_failed++; $display("FAIL midop_size: got %b want 010", memUnitSize);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        tests_run++;
        if (reqReady !== 1'b1) begin
            tests_failed++; $display("FAIL midop_ready: got %b want 1", reqReady);
        end
        check_mem(12'h400, 8'h00);
        check_mem(12'h401, 8'hD4);
        check_mem(12'h402, 8'hC3);
        check_mem(12'h403, 8'h00);
        check_mem(12'h404, 8'h00);
        $display("[TB] reset mid split store: mem401=%h mem402=%h mem403=%h", mem[12'h401], mem[12'h402], mem[12'h403]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; mem_clr_req = 1'b1;
        reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = 3'b000; reqAddr = 32'h0; reqWriteData = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_clr_req = 1'b0;
        rstn = 1'b1;
        test_reset();
        test_aligned_store();
        test_aligned_load();
        test_misaligned_load();
        test_misaligned_store();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_mid_op();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++; $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
